tft_box_controller: RTL
=======================

// Module: tft_box_controller
// PURPOSE
// Frame-synchronous controller that sequences the box position fed to tft_driver (xcorner/ycorner).
// On each accepted new_frame pulse it computes the next box position, with bounce at the screen
// edges, and commits X and Y together. The driver therefore never sees a torn position mid-frame.
// Sits between user controls (enable/step/speed/load) and tft_driver, in the tft_clk domain.
// PARAMETERS
// H_ACTIVE  480  visible pixels per line
// V_ACTIVE  272  visible lines per frame
// BOX_W     32   box width in pixels; XMAX = H_ACTIVE-BOX_W (448)
// BOX_H     32   box height in lines; YMAX = V_ACTIVE-BOX_H (240)
// PORTS
// tft_clk      in   1   pixel clock, shared with tft_driver
// rst          in   1   asynchronous reset, active-high
// new_frame    in   1   1-cycle pulse from tft_driver at frame start
// enable       in   1   1 = free-run: update on every new_frame
// step         in   1   1-cycle pulse; requests exactly one update at the next new_frame
// speed        in   4   pixels moved per axis per update (0..15)
// load         in   1   1-cycle pulse; forces position to load_x/load_y
// load_x       in   10  load X value; clamped to XMAX
// load_y       in   9   load Y value; clamped to YMAX
// xcorner      out  10  committed box X, to tft_driver
// ycorner      out  9   committed box Y, to tft_driver
// busy         out  1   high while FSM not in IDLE
// bounce       out  1   1-cycle pulse in COMMIT if either axis reflected
// overrun      out  1   sticky: new_frame arrived while busy
// frame_count  out  16  count of committed updates; wraps FFFF->0000
// BEHAVIOUR
// - Reset (async, any state): FSM=IDLE; xcorner=0, ycorner=0; dir_x=+, dir_y=+; busy=0, bounce=0,
//   overrun=0, frame_count=0; step_pend=0; shadow nx/ny=0.
// - FSM: IDLE -> CALC_X -> CALC_Y -> COMMIT -> IDLE; one cycle per non-IDLE state.
// - Accept rule: in IDLE, new_frame && (enable || step_pend) -> CALC_X; clear step_pend.
// - step sets step_pend (held until consumed). step in the same cycle as an accepted new_frame
//   is consumed by that frame.
// - CALC_X: use an 11-bit sum. dir + : nx = x+speed; if nx >= XMAX then nx = XMAX, flip dir_x to -,
//   flag bx.
// - CALC_X: dir - : if speed >= x then nx = 0, flip dir_x to +, flag bx; else nx = x-speed.
// - CALC_Y: same rules with YMAX, flags by. Landing exactly on a limit counts as a bounce.
// - speed=0: position unchanged, no bounce, no direction flip. FSM still runs; frame_count still
//   increments.
// - COMMIT: xcorner<=nx and ycorner<=ny in the same edge; bounce=bx|by for 1 cycle;
//   frame_count+1.
// - Latency: new_frame at cycle N -> busy high N+1..N+3 -> outputs change at edge ending N+3
//   (visible at N+4).
// - new_frame while busy: ignored, overrun<=1. overrun is cleared only by load or rst.
// - load: highest priority, any state. Aborts an in-flight update (no commit, no frame_count
//   change). Next edge: xcorner=min(load_x,XMAX), ycorner=min(load_y,YMAX), dirs=+,+,
//   FSM=IDLE, overrun=0.
// - load and new_frame in the same cycle: load wins; that frame is not accepted.
// - Outputs change only in COMMIT or on load; held otherwise.
// TESTING
// 1 rst, enable=1, speed=4, pulse new_frame -> busy 3 cycles; xcorner=4, ycorner=4,
//   frame_count=1, bounce=0.
// 2 load(446,238), speed=4, two frames -> (448,240) with one bounce pulse, then (444,236),
//   bounce=0.
// 3 load(3,50), run right to left wall: after the flip, with speed=5 and x=3 -> x=0, bounce,
//   next frame x=5.
// 4 enable=0, step pulse mid-frame, three new_frames -> exactly one update, frame_count +1 only.
// 5 load(100,100) during CALC_Y -> next edge outputs (100,100), frame_count unchanged, busy=0.
// 6 new_frame during CALC_X -> overrun=1 and stays 1; assert rst in CALC_Y -> all outputs 0
//   immediately.

Source files
------------

// File: rtl/tft_box_controller.sv
// tft_box_controller
// Frame-synchronous sequencer for the box corner fed to tft_driver. Each accepted
// new_frame runs CALC_X -> CALC_Y -> COMMIT. The next position is computed into
// shadow registers and both axes are committed on the same edge. The driver never
// sees a torn X/Y pair.
// Ports:
//   i_tft_clk      pixel clock shared with tft_driver
//   i_rst          asynchronous reset, active-high
//   i_new_frame    1-cycle frame-start pulse from tft_driver
//   i_enable       free-run: update on every new_frame
//   i_step         1-cycle pulse: request one update at the next new_frame
//   i_speed        pixels moved per axis per update
//   i_load         1-cycle pulse: force position to the clamped i_load_x/i_load_y
//   i_load_x/y     load position
//   o_xcorner/y    committed box corner
//   o_busy         FSM not idle
//   o_bounce       1-cycle pulse with a commit in which either axis reflected
//   o_overrun      sticky: new_frame seen while busy (cleared by load or reset)
//   o_frame_count  number of committed updates, wrapping
module tft_box_controller #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int BOX_W    = 32,
  parameter int BOX_H    = 32
) (
  input  logic        i_tft_clk,
  input  logic        i_rst,
  input  logic        i_new_frame,
  input  logic        i_enable,
  input  logic        i_step,
  input  logic [3:0]  i_speed,
  input  logic        i_load,
  input  logic [9:0]  i_load_x,
  input  logic [8:0]  i_load_y,
  output logic [9:0]  o_xcorner,
  output logic [8:0]  o_ycorner,
  output logic        o_busy,
  output logic        o_bounce,
  output logic        o_overrun,
  output logic [15:0] o_frame_count
);

  localparam logic [9:0]  XMAX    = 10'(H_ACTIVE - BOX_W);
  localparam logic [8:0]  YMAX    = 9'(V_ACTIVE - BOX_H);
  localparam logic [10:0] XMAX_11 = {1'b0, XMAX};
  localparam logic [10:0] YMAX_11 = {2'b0, YMAX};

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  state_t      r_state, w_state_next;
  logic [9:0]  r_x, r_nx, w_nx;
  logic [8:0]  r_y, r_ny, w_ny;
  logic        r_dir_x, r_dir_y;   // 1 = moving in the + direction
  logic        r_ndir_x, r_ndir_y; // shadow directions, committed with the position
  logic        r_bx, r_by, w_bx, w_by;
  logic        r_step_pend, r_bounce, r_overrun;
  logic [15:0] r_frame_count;
  logic [10:0] w_x_sum, w_y_sum, w_speed_11;
  logic        w_accept;

  // A load in the same cycle always wins over a frame start.
  assign w_accept = (r_state == IDLE) && i_new_frame && !i_load &&
                    (i_enable || r_step_pend);

  always_ff @(posedge i_tft_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = CALC_X;
      CALC_X:  w_state_next = CALC_Y;
      CALC_Y:  w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (i_load) w_state_next = IDLE;
  end

  // Next-position arithmetic. The sums are 11 bits wide so x+speed cannot wrap.
  // Speed 0 is excluded explicitly so a box resting on a limit does not reflect.
  assign w_speed_11 = {7'b0, i_speed};
  assign w_x_sum    = {1'b0, r_x} + w_speed_11;
  assign w_y_sum    = {2'b0, r_y} + w_speed_11;

  always_comb begin
    w_nx = r_x;
    w_bx = 1'b0;
    if (i_speed != 4'd0) begin
      if (r_dir_x) begin
        if (w_x_sum >= XMAX_11) begin w_nx = XMAX; w_bx = 1'b1; end
        else                          w_nx = w_x_sum[9:0];
      end else begin
        if (w_speed_11 >= {1'b0, r_x}) begin w_nx = 10'd0; w_bx = 1'b1; end
        else                                 w_nx = r_x - {6'b0, i_speed};
      end
    end
  end

  always_comb begin
    w_ny = r_y;
    w_by = 1'b0;
    if (i_speed != 4'd0) begin
      if (r_dir_y) begin
        if (w_y_sum >= YMAX_11) begin w_ny = YMAX; w_by = 1'b1; end
        else                          w_ny = w_y_sum[8:0];
      end else begin
        if (w_speed_11 >= {2'b0, r_y}) begin w_ny = 9'd0; w_by = 1'b1; end
        else                                 w_ny = r_y - {5'b0, i_speed};
      end
    end
  end

  always_ff @(posedge i_tft_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_nx          <= '0;
      r_ny          <= '0;
      r_dir_x       <= 1'b1;
      r_dir_y       <= 1'b1;
      r_ndir_x      <= 1'b1;
      r_ndir_y      <= 1'b1;
      r_bx          <= 1'b0;
      r_by          <= 1'b0;
      r_step_pend   <= 1'b0;
      r_bounce      <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_bounce <= 1'b0;
      // A step arriving with the accepted frame is absorbed by that frame.
      if (w_accept)    r_step_pend <= 1'b0;
      else if (i_step) r_step_pend <= 1'b1;

      if (i_load) begin
        r_x       <= (i_load_x > XMAX) ? XMAX : i_load_x;
        r_y       <= (i_load_y > YMAX) ? YMAX : i_load_y;
        r_dir_x   <= 1'b1;
        r_dir_y   <= 1'b1;
        r_overrun <= 1'b0;
      end else begin
        if (i_new_frame && (r_state != IDLE)) r_overrun <= 1'b1;
        case (r_state)
          CALC_X: begin
            r_nx     <= w_nx;
            r_bx     <= w_bx;
            r_ndir_x <= w_bx ? ~r_dir_x : r_dir_x;
          end
          CALC_Y: begin
            r_ny     <= w_ny;
            r_by     <= w_by;
            r_ndir_y <= w_by ? ~r_dir_y : r_dir_y;
          end
          COMMIT: begin
            r_x           <= r_nx;
            r_y           <= r_ny;
            r_dir_x       <= r_ndir_x;
            r_dir_y       <= r_ndir_y;
            r_bounce      <= r_bx | r_by;
            r_frame_count <= r_frame_count + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_xcorner     = r_x;
  assign o_ycorner     = r_y;
  assign o_busy        = (r_state != IDLE);
  assign o_bounce      = r_bounce;
  assign o_overrun     = r_overrun;
  assign o_frame_count = r_frame_count;

endmodule
